led7seg_scan: RTL

Two-digit multiplexed 7-segment display driver for the mod-60 counter display path. It consumes the BCD `tens`/`digits` pair produced by the counter stage, which may run on a slower, unrelated clock. It double-registers the pair and snapshots it once per scan frame, then time-multiplexes the two digits onto one shared segment bus with a dead cycle between digits. The block sits between the counter and the board's LED pins.

---
 rtl/led7seg_scan.sv | 117 +++++++++++
 1 files changed

// File: rtl/led7seg_scan.sv
`default_nettype none
// ============================================================================
// led7seg_scan : two-digit multiplexed 7-segment driver with frame snapshot
// Revision 1.0 - initial release
// ============================================================================
module led7seg_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int COMMON_ANODE = 1,
  parameter int BLANK_LZ     = 0
) (
  input  logic       Clk,
  input  logic       RST_n,
  input  logic [3:0] tens,
  input  logic [3:0] digits,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int             CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  C_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic           C_INV     = (COMMON_ANODE != 0);
  localparam logic [6:0]     C_SEG_OFF = C_INV ? 7'h7F : 7'h00;
  localparam logic [1:0]     C_AN_OFF  = C_INV ? 2'b11 : 2'b00;
  localparam logic [6:0]     C_SEG_INV = {7{C_INV}};
  localparam logic [1:0]     C_AN_INV  = {2{C_INV}};

  typedef enum logic [0:0] {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } state_t;

  logic [7:0]    r_s1;
  logic [7:0]    r_s2;
  logic [3:0]    r_sh_tens;
  logic [3:0]    r_sh_dig;
  logic [CW-1:0] r_cnt;
  state_t        r_state;

  logic          w_tick;
  logic          w_stable;
  logic          w_blank;
  logic [6:0]    w_seg_dig;
  logic [6:0]    w_seg_tens;

  // Segment patterns are active-high {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'b0111111;
      4'd1:    r = 7'b0000110;
      4'd2:    r = 7'b1011011;
      4'd3:    r = 7'b1001111;
      4'd4:    r = 7'b1100110;
      4'd5:    r = 7'b1101101;
      4'd6:    r = 7'b1111101;
      4'd7:    r = 7'b0000111;
      4'd8:    r = 7'b1111111;
      4'd9:    r = 7'b1101111;
      default: r = 7'b1000000;
    endcase
    return r;
  endfunction

  assign w_tick     = (r_cnt == C_LAST);
  assign w_stable   = (r_s1 == r_s2);
  assign w_blank    = (BLANK_LZ != 0) && (r_sh_tens == 4'd0);
  assign w_seg_dig  = f_decode(r_sh_dig);
  assign w_seg_tens = f_decode(r_sh_tens);

  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {tens, digits};
      r_s2 <= r_s1;
    end
  end

  // Shadows only change at the DIG1->DIG0 boundary so a frame is always coherent.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt     <= '0;
      r_state   <= DIG0;
      r_sh_tens <= '0;
      r_sh_dig  <= '0;
      seg       <= C_SEG_OFF;
      an        <= C_AN_OFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        seg <= C_SEG_OFF;
        an  <= C_AN_OFF;
        if (r_state == DIG0) begin
          r_state <= DIG1;
        end else begin
          r_state <= DIG0;
          if (w_stable) begin
            r_sh_tens <= r_s2[7:4];
            r_sh_dig  <= r_s2[3:0];
          end
        end
      end else if (r_state == DIG0) begin
        seg <= w_seg_dig ^ C_SEG_INV;
        an  <= 2'b01 ^ C_AN_INV;
      end else if (w_blank) begin
        seg <= C_SEG_OFF;
        an  <= C_AN_OFF;
      end else begin
        seg <= w_seg_tens ^ C_SEG_INV;
        an  <= 2'b10 ^ C_AN_INV;
      end
    end
  end

endmodule
`default_nettype wire
